// File: rtl/meissa_column_acc.sv
// Multi-lane multiply-accumulate column with a programmable beat count,
// signed/unsigned saturating arithmetic and a valid/ready one-entry result register.
module meissa_column_acc #(
  parameter int unsigned COLUMN_WIDTH = 9,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned MAC_WIDTH    = 32,
  parameter int unsigned LEN_WIDTH    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [LEN_WIDTH-1:0]               cfg_len,
  input  logic                               cfg_signed,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH*COLUMN_WIDTH-1:0] datain,
  input  logic [DATA_WIDTH*COLUMN_WIDTH-1:0] weight,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [MAC_WIDTH*COLUMN_WIDTH-1:0]  maccout,
  output logic [COLUMN_WIDTH-1:0]            out_sat
);

  typedef enum logic {S_IDLE, S_ACCUM} state_e;

  state_e                                 state_q, state_d;
  logic [LEN_WIDTH-1:0]                   cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]                   len_q, len_d;
  logic                                   signed_q, signed_d;
  logic [COLUMN_WIDTH-1:0][MAC_WIDTH-1:0] acc_q, acc_d;
  logic [COLUMN_WIDTH-1:0][MAC_WIDTH-1:0] maccout_q, maccout_d;
  logic [COLUMN_WIDTH-1:0]                flag_q, flag_d;
  logic [COLUMN_WIDTH-1:0]                out_sat_q, out_sat_d;
  logic                                   out_valid_q, out_valid_d;

  logic [COLUMN_WIDTH-1:0][MAC_WIDTH-1:0] acc_next;
  logic [COLUMN_WIDTH-1:0]                flag_next;
  logic [LEN_WIDTH-1:0]                   cfg_len_eff;
  logic                                   first_beat;
  logic                                   mode_signed;
  logic                                   completing;
  logic                                   accept;

  logic [DATA_WIDTH-1:0]                  lane_a, lane_w;
  logic [2*DATA_WIDTH-1:0]                prod_u;
  logic signed [2*DATA_WIDTH-1:0]         prod_s;
  logic [2*DATA_WIDTH-1:0]                prod;
  logic [MAC_WIDTH:0]                     prod_x;
  logic [MAC_WIDTH-1:0]                   base;
  logic [MAC_WIDTH:0]                     sum;
  logic                                   clamp;

  assign first_beat  = (state_q == S_IDLE);
  assign mode_signed = first_beat ? cfg_signed : signed_q;
  assign cfg_len_eff = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
  assign completing  = first_beat ? (cfg_len_eff == LEN_WIDTH'(1))
                                  : (cnt_q == len_q - LEN_WIDTH'(1));

  // Only a completing beat needs room in the result register.
  assign in_ready = reset && !(completing && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    acc_next  = '0;
    flag_next = '0;
    lane_a    = '0;
    lane_w    = '0;
    prod_u    = '0;
    prod_s    = '0;
    prod      = '0;
    prod_x    = '0;
    base      = '0;
    sum       = '0;
    clamp     = 1'b0;
    for (int unsigned i = 0; i < COLUMN_WIDTH; i++) begin
      lane_a = datain[i*DATA_WIDTH +: DATA_WIDTH];
      lane_w = weight[i*DATA_WIDTH +: DATA_WIDTH];
      prod_u = lane_a * lane_w;
      prod_s = $signed(lane_a) * $signed(lane_w);
      prod   = mode_signed ? $unsigned(prod_s) : prod_u;
      prod_x = {{(MAC_WIDTH+1-2*DATA_WIDTH){mode_signed & prod[2*DATA_WIDTH-1]}}, prod};
      base   = first_beat ? '0 : acc_q[i];
      sum    = {mode_signed & base[MAC_WIDTH-1], base} + prod_x;
      clamp  = 1'b0;
      acc_next[i] = sum[MAC_WIDTH-1:0];
      // Signed overflow shows as the two top bits of the widened sum disagreeing.
      if (mode_signed) begin
        if (sum[MAC_WIDTH] != sum[MAC_WIDTH-1]) begin
          clamp       = 1'b1;
          acc_next[i] = sum[MAC_WIDTH] ? {1'b1, {(MAC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(MAC_WIDTH-1){1'b1}}};
        end
      end else if (sum[MAC_WIDTH]) begin
        clamp       = 1'b1;
        acc_next[i] = '1;
      end
      flag_next[i] = clamp | (!first_beat & flag_q[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    signed_d    = signed_q;
    acc_d       = acc_q;
    flag_d      = flag_q;
    maccout_d   = maccout_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept) begin
      if (first_beat) begin
        len_d    = cfg_len_eff;
        signed_d = cfg_signed;
      end
      acc_d  = acc_next;
      flag_d = flag_next;
      if (completing) begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        maccout_d   = acc_next;
        out_sat_d   = flag_next;
        out_valid_d = 1'b1;
      end else begin
        state_d = S_ACCUM;
        cnt_d   = cnt_q + LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      signed_q    <= 1'b0;
      acc_q       <= '0;
      flag_q      <= '0;
      maccout_q   <= '0;
      out_sat_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      signed_q    <= signed_d;
      acc_q       <= acc_d;
      flag_q      <= flag_d;
      maccout_q   <= maccout_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign maccout   = maccout_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/meissa_column_acc.md
# meissa_column_acc

Parametrised successor to the Meissa MAC column: `COLUMN_WIDTH` independent multiply-accumulate lanes share one handshake. Each lane accumulates `datain × weight` over a runtime-programmable number of beats, in signed or unsigned mode, with saturation. It then hands the finished column result to a one-entry output register using valid/ready flow control. It sits between the operand skew/feed logic and the result drain path of the NPU array, replacing the free-running per-cycle PE column where output backpressure and variable accumulation depth are needed.

## Interface
Parameters:
- `COLUMN_WIDTH`, 9: number of MAC lanes.
- `DATA_WIDTH`, 16: width of each operand lane.
- `MAC_WIDTH`, 32: accumulator and result width per lane. Must be ≥ 2·`DATA_WIDTH`.
- `LEN_WIDTH`, 8: width of the accumulation-length field.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `cfg_len`  in  `LEN_WIDTH`  beats per accumulation. Sampled on the first beat only. 0 is treated as 1.
- `cfg_signed`  in  1  1 = two's-complement operands, 0 = unsigned. Sampled on the first beat only.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `datain`  in  `DATA_WIDTH*COLUMN_WIDTH`  lane i = bits `[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]`.
- `weight`  in  `DATA_WIDTH*COLUMN_WIDTH`  same lane packing as `datain`.
- `out_valid`  out  1  result register holds an undrained result.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `maccout`  out  `MAC_WIDTH*COLUMN_WIDTH`  per-lane result, packed like `datain`.
- `out_sat`  out  `COLUMN_WIDTH`  per-lane sticky flag: saturation occurred during this result's accumulation.

## Operation
- State machine:
  - IDLE: accumulator empty. On an accepted beat:
    - latch `len_q = max(cfg_len,1)` and `signed_q = cfg_signed`;
    - set `acc_i = sat(ext(product_i))`, `cnt = 1`;
    - go to ACCUM.
    - If `len_q == 1`, the beat completes instead and the state stays IDLE.
  - ACCUM: on an accepted beat, `acc_i = sat(acc_i + ext(product_i))` and `cnt++`.
    - When the accepted beat is beat number `len_q` (that is, `cnt == len_q-1` before the edge), it completes; return to IDLE.
  - `cfg_*` is ignored in ACCUM.
- Arithmetic (per lane):
  - `product_i` is the full 2·`DATA_WIDTH`-bit product, signed or unsigned per `signed_q`.
  - `ext()` sign-extends (signed) or zero-extends (unsigned) the product to `MAC_WIDTH`+1 bits.
  - Addition is done at `MAC_WIDTH`+1 bits, then `sat()` clamps:
    - signed: to [−2^(`MAC_WIDTH`−1), 2^(`MAC_WIDTH`−1)−1];
    - unsigned: to [0, 2^`MAC_WIDTH`−1].
  - A lane's internal sat flag is set whenever a clamp fires. It is cleared on the first beat of a new accumulation.
- Completion: `maccout ← acc_next` (the saturated value including the completing beat), `out_sat ← flags_next`, `out_valid ← 1`.
- Drain: `out_valid && out_ready` clears `out_valid`. When a drain and a completion happen on the same edge, `out_valid` stays 1 and the new result is loaded.
- Backpressure:
  - `in_ready = reset && !(completing_beat_pending && out_valid && !out_ready)`, where `completing_beat_pending` means the next accepted beat would complete.
  - Non-completing beats are never stalled. `out_ready` feeds `in_ready` combinationally.
- Beats with `in_valid` low leave all state unchanged.

## Timing
- Reset (`reset == 0` at an edge) sets: state IDLE, `cnt = 0`, `acc_i = 0`, internal flags 0, `out_valid = 0`, `maccout = 0`, `out_sat = 0`.
  - `in_ready` is 0 while `reset` is low.
  - An accumulation or undrained result in progress when reset asserts is discarded. No partial output is produced.
- Latency: when the completing beat is accepted at edge N, `out_valid` and `maccout` are visible from edge N, i.e. for the whole following cycle. Each beat is a single-cycle MAC with no internal pipeline.
- Throughput: one beat per cycle. Back-to-back accumulations need no idle cycle; the first beat of the next accumulation may be accepted on the edge right after a completion.
- `maccout` and `out_sat` are held stable while `out_valid && !out_ready`.
- `cnt` width is `LEN_WIDTH`. For `cfg_len = 2^LEN_WIDTH−1`, `cnt` never wraps.

## Test plan
- **Reset and idle:** hold `reset` = 0 for 3 cycles with `in_valid` = 1 → `in_ready` = 0 and `out_valid` = 0, `maccout` = 0; no beat is consumed.
- **Unsigned, len 4:**
  - Stimulus: every lane gets datain = 3, weight = 5 on 4 consecutive beats, with `out_ready` = 1.
  - Response: on the cycle after the 4th beat, `out_valid` = 1 and every lane = 60, `out_sat` = 0. `out_valid` drops after one cycle.
- **Signed mixed lanes, len 2:**
  - Stimulus: lane0 = (−2)·7 then 3·3; lane1 = 0x8000·0x8000 twice.
  - Response: lane0 = −5; lane1 = 2^31 saturates to 0x7FFF_FFFF with `out_sat[1]` = 1 and `out_sat[0]` = 0.
- **Backpressure:**
  - Stimulus: `out_ready` = 0 after the first result; stream a second len-2 accumulation.
  - Response: beat 1 is accepted; `in_ready` = 0 before beat 2 and the first result is held unchanged. Raise `out_ready` → the first result drains and beat 2 is accepted on the same edge; the second result appears next cycle.
- **cfg_len = 0 and cfg change mid-run:**
  - Stimulus: `cfg_len` = 0 → every beat completes on its own. Then start with len 3 and change `cfg_len` to 1 and `cfg_signed` mid-run.
  - Response: the run still takes 3 beats in the original mode.
- **Reset mid-accumulation:**
  - Stimulus: assert `reset` after beat 2 of a len-4 run, then release and run a fresh len-1 run with 1·1.
  - Response: `maccout` = 1 in every lane, with no residue from the aborted run.
